leading_one_decode: RTL

//  Inverse of the leading-one detector: takes a {found, index} position word and

---
 rtl/leading_one_decode.sv | 133 +++++++++++++
 1 files changed

// File: rtl/leading_one_decode.sv
// leading_one_decode
//   Rebuilds a bit vector from a leading-one position word {found, index}.
//   Produces a one-hot vector with only bit[index] set and a thermometer mask
//   with bits [index:0] set. Two registered stages with a valid/ready handshake
//   and full backpressure; a word accepted on one edge is presented on out_*
//   after the following edge when nothing stalls.
//
// Parameters
//   xWL       vector width in bits (>= 2)
//   ctrWidth  index width, enough bits to hold xWL-1
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   ce          clock enable; 0 freezes every register and blocks input
//   in_valid    input word valid
//   in_ready    block accepts input this cycle
//   in_pos      {found, index}; MSB = found
//   out_valid   output word valid
//   out_ready   downstream accepts output
//   out_onehot  bit[index] set, all others clear
//   out_mask    bits [index:0] set, bits above index clear
//   out_found   copy of the input found bit
//   out_err     found=1 with index beyond xWL-1
module leading_one_decode #(
    parameter int xWL      = 32,
    // $clog2(v+1) is the number of bits needed to hold v; here v = xWL-1.
    parameter int ctrWidth = $clog2(xWL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ctrWidth:0]   in_pos,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [xWL-1:0]      out_onehot,
    output logic [xWL-1:0]      out_mask,
    output logic                out_found,
    output logic                out_err
);

    localparam logic [xWL:0] ONE_W = (xWL+1)'(1);
    localparam logic [xWL:0] TWO_W = (xWL+1)'(2);

    logic                s1_valid;
    logic                s1_found;
    logic [ctrWidth-1:0] s1_idx;
    logic                s1_err;
    logic                s2_valid;

    logic                s1_load;
    logic                s2_load;

    logic                in_found;
    logic [ctrWidth-1:0] in_idx;
    logic                in_range_err;

    logic [xWL:0]        onehot_wide;
    logic [xWL:0]        mask_wide;
    logic [xWL-1:0]      dec_onehot;
    logic [xWL-1:0]      dec_mask;
    logic                unused_wide_msbs;

    assign in_found = in_pos[ctrWidth];
    assign in_idx   = in_pos[ctrWidth-1:0];

    // An out-of-range index exists only when the index field can encode more
    // values than there are bits; otherwise the compare would be constant.
    generate
        if ((2 ** ctrWidth) > xWL) begin : g_range_chk
            localparam logic [ctrWidth-1:0] MAX_IDX = ctrWidth'(xWL - 1);
            assign in_range_err = in_found && (in_idx > MAX_IDX);
        end else begin : g_no_range_chk
            assign in_range_err = 1'b0;
        end
    endgenerate

    // Handshake: S2 drains or is empty -> S2 loads; S1 advances into it.
    assign s2_load  = ce && (!s2_valid || out_ready);
    assign s1_load  = ce && (!s1_valid || s2_load);
    assign in_ready = s1_load;

    // Shifts are done one bit wider so index = xWL-1 yields an all-ones mask.
    assign onehot_wide = ONE_W << s1_idx;
    assign mask_wide   = (TWO_W << s1_idx) - ONE_W;

    always_comb begin
        dec_onehot = '0;
        dec_mask   = '0;
        if (s1_found && !s1_err) begin
            dec_onehot = onehot_wide[xWL-1:0];
            dec_mask   = mask_wide[xWL-1:0];
        end
    end

    // Top bits of the wide results are always zero for in-range indices.
    assign unused_wide_msbs = onehot_wide[xWL] ^ mask_wide[xWL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_found <= 1'b0;
            s1_idx   <= '0;
            s1_err   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            s1_found <= in_found;
            s1_idx   <= in_idx;
            s1_err   <= in_range_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_onehot <= '0;
            out_mask   <= '0;
            out_found  <= 1'b0;
            out_err    <= 1'b0;
        end else if (s2_load) begin
            s2_valid   <= s1_valid;
            out_onehot <= dec_onehot;
            out_mask   <= dec_mask;
            out_found  <= s1_found;
            out_err    <= s1_err;
        end
    end

    assign out_valid = s2_valid;

endmodule
